lock_attempt_ctrl: RTL and testbench

Access-attempt controller that sequences the code-check datapath. It accepts a user start request and issues a one-cycle start pulse to the checker. It waits for the checker's verdict, counts consecutive failures, and grants access on a correct verdict. After MAX_FAILS consecutive failures it enters a timed lockout and asserts blocked, which gates further starts.

---
 rtl/lock_attempt_ctrl_pkg.sv | 20 ++
 rtl/lock_attempt_ctrl_if.sv | 27 ++
 rtl/lock_attempt_ctrl_timer.sv | 30 +++
 rtl/lock_attempt_ctrl.sv | 129 ++++++++++++
 tb/tb_lock_attempt_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/lock_attempt_ctrl_pkg.sv
// Shared state encoding and sizing helper for the lock-attempt controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lock_pkg;

  // State encoding is visible on the estado port, so it is fixed here.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_GRANTED = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/lock_attempt_ctrl_if.sv
// User/checker-facing signal bundle of the lock-attempt controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle or level qualified.
interface lock_attempt_ctrl_if #(
  parameter int FAIL_W = 2
);
  logic              iniciar;
  logic              res_valid;
  logic              res_correct;
  logic              chk_start;
  logic              granted;
  logic              blocked;
  logic [FAIL_W-1:0] fail_cnt;
  logic [1:0]        estado;

  // Environment side: drives requests and verdicts, observes status.
  modport master (
    output iniciar, res_valid, res_correct,
    input  chk_start, granted, blocked, fail_cnt, estado
  );

  // Controller side.
  modport slave (
    input  iniciar, res_valid, res_correct,
    output chk_start, granted, blocked, fail_cnt, estado
  );
endinterface

// File: rtl/lock_attempt_ctrl_timer.sv
// Loadable down-counter; zero is high while the count is 0.
// Latency: load takes effect next cycle; zero is a decode of the count register.
// Backpressure: none; en simply pauses the count, which holds at 0.
module lock_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load has priority over counting; the count stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Count register, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/lock_attempt_ctrl.sv
// Access-attempt sequencer: start pulse, verdict wait, fail counting, timed lockout.
// Latency: one cycle from sampled input to registered outputs.
// Backpressure: blocked gates starts during lockout; optional LOCK_ATTEMPT_TIMEOUT_EN adds a CHECK timeout.
module lock_attempt_ctrl
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int FAIL_W         = 2
) (
  input  logic               clock,
  input  logic               reset,
  lock_attempt_ctrl_if.slave bus
);
  localparam int                LOCK_W    = clog2_min1(LOCK_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_SAT  = FAIL_W'(MAX_FAILS);

  // Reject configurations that cannot work at elaboration time.
  if (MAX_FAILS < 1 || LOCK_CYCLES < 1 || TIMEOUT_CYCLES < 1 || (1 << FAIL_W) <= MAX_FAILS) begin : g_param_err
    $error("lock_attempt_ctrl: illegal parameter combination");
  end

  logic [1:0]        state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              chk_start_q, chk_start_d;
  logic              granted_q, granted_d;
  logic              blocked_q, blocked_d;
  logic              lock_load, lock_zero;
  logic              timeout_exp;

  // Lockout timer: loaded on the transition into LOCKED, counts while LOCKED.
  assign lock_load = (state_q == ST_CHECK) && (state_d == ST_LOCKED);

  lock_timer #(.WIDTH(LOCK_W)) u_lock_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (lock_load),
    .load_val (LOCK_LOAD),
    .en       (state_q == ST_LOCKED),
    .zero     (lock_zero)
  );

`ifdef LOCK_ATTEMPT_TIMEOUT_EN
  localparam int               TMO_W    = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  logic tmo_load;

  // Timeout timer starts with every entry into CHECK; its zero is the expiry.
  assign tmo_load = (state_q == ST_IDLE) && bus.iniciar;

  lock_timer #(.WIDTH(TMO_W)) u_tmo_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmo_load),
    .load_val (TMO_LOAD),
    .en       (state_q == ST_CHECK),
    .zero     (timeout_exp)
  );
`else
  assign timeout_exp = 1'b0;
`endif

  // Next state and fail counter; a verdict in the expiry cycle takes precedence.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iniciar) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bus.res_valid && bus.res_correct) begin
          state_d = ST_GRANTED;
          fail_d  = '0;
        end else if (bus.res_valid || timeout_exp) begin
          if (int'(fail_q) + 1 < MAX_FAILS) begin
            state_d = ST_IDLE;
            fail_d  = fail_q + 1'b1;
          end else begin
            state_d = ST_LOCKED;
            fail_d  = FAIL_SAT;
          end
        end
      end
      ST_GRANTED: begin
        if (bus.iniciar) state_d = ST_IDLE;
      end
      ST_LOCKED: begin
        if (lock_zero) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values decoded from the upcoming state so outputs stay registered.
  always_comb begin
    chk_start_d = (state_q == ST_IDLE) && (state_d == ST_CHECK);
    granted_d   = (state_d == ST_GRANTED);
    blocked_d   = (state_d == ST_LOCKED);
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fail_q      <= '0;
      chk_start_q <= 1'b0;
      granted_q   <= 1'b0;
      blocked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_q      <= fail_d;
      chk_start_q <= chk_start_d;
      granted_q   <= granted_d;
      blocked_q   <= blocked_d;
    end
  end

  assign bus.chk_start = chk_start_q;
  assign bus.granted   = granted_q;
  assign bus.blocked   = blocked_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.estado    = state_q;
endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Self-checking bench for lock_attempt_ctrl (MAX_FAILS=3, LOCK_CYCLES=16, TIMEOUT_CYCLES=8).
// Each step drives inputs, queues the expected registered outputs, and checks them after the edge.
// Build with LOCK_ATTEMPT_TIMEOUT_EN defined to cover the timeout path.
module tb_lock_attempt_ctrl;
  localparam int FAIL_W = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lock_attempt_ctrl_if #(.FAIL_W(FAIL_W)) bus ();

  lock_attempt_ctrl #(
    .MAX_FAILS      (3),
    .LOCK_CYCLES    (16),
    .TIMEOUT_CYCLES (8),
    .FAIL_W         (FAIL_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       ini, rv, rc;
    logic       chk, gr, bl;
    logic [1:0] fc;
    logic [1:0] st;
  } vec_t;

  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input bit ini, input bit rv, input bit rc,
                              input bit chk, input bit gr, input bit bl,
                              input int fc, input int st);
    vec_t v;
    v.ini = ini; v.rv = rv; v.rc = rc;
    v.chk = chk; v.gr = gr; v.bl = bl;
    v.fc  = 2'(fc);
    v.st  = 2'(st);
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Drive one cycle of stimulus and compare the registered outputs after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    bus.iniciar     = v.ini;
    bus.res_valid   = v.rv;
    bus.res_correct = v.rc;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".chk_start"}, 8'(bus.chk_start), 8'(e.chk));
      check({tag, ".granted"},   8'(bus.granted),   8'(e.gr));
      check({tag, ".blocked"},   8'(bus.blocked),   8'(e.bl));
      check({tag, ".fail_cnt"},  8'(bus.fail_cnt),  8'(e.fc));
      check({tag, ".estado"},    8'(bus.estado),    8'(e.st));
    end
  endtask

  vec_t tab_a[13];
  vec_t tab_b[13];

  initial begin
    // Grant, ignored verdicts, three failures into lockout.
    tab_a[0]  = mk(1,0,0, 1,0,0,0,1);
    tab_a[1]  = mk(0,0,0, 0,0,0,0,1);
    tab_a[2]  = mk(0,1,1, 0,1,0,0,2);
    tab_a[3]  = mk(0,1,0, 0,1,0,0,2);
    tab_a[4]  = mk(1,0,0, 0,0,0,0,0);
    tab_a[5]  = mk(0,1,0, 0,0,0,0,0);
    tab_a[6]  = mk(1,0,0, 1,0,0,0,1);
    tab_a[7]  = mk(0,1,0, 0,0,0,1,0);
    tab_a[8]  = mk(1,0,0, 1,0,0,1,1);
    tab_a[9]  = mk(1,0,0, 0,0,0,1,1);
    tab_a[10] = mk(0,1,0, 0,0,0,2,0);
    tab_a[11] = mk(1,0,0, 1,0,0,2,1);
    tab_a[12] = mk(0,1,0, 0,0,1,3,3);
    // Post-lockout start, two fails, zero-latency correct verdict, three fails to lock.
    tab_b[0]  = mk(1,0,0, 1,0,0,0,1);
    tab_b[1]  = mk(0,1,0, 0,0,0,1,0);
    tab_b[2]  = mk(1,0,0, 1,0,0,1,1);
    tab_b[3]  = mk(0,1,0, 0,0,0,2,0);
    tab_b[4]  = mk(1,1,1, 1,0,0,2,1);
    tab_b[5]  = mk(0,1,1, 0,1,0,0,2);
    tab_b[6]  = mk(1,0,0, 0,0,0,0,0);
    tab_b[7]  = mk(1,0,0, 1,0,0,0,1);
    tab_b[8]  = mk(0,1,0, 0,0,0,1,0);
    tab_b[9]  = mk(1,0,0, 1,0,0,1,1);
    tab_b[10] = mk(0,1,0, 0,0,0,2,0);
    tab_b[11] = mk(1,0,0, 1,0,0,2,1);
    tab_b[12] = mk(0,1,0, 0,0,1,3,3);

    bus.iniciar = 1'b0; bus.res_valid = 1'b0; bus.res_correct = 1'b0;

    // Reset state.
    reset = 1'b1;
    step(mk(1,1,1, 0,0,0,0,0), "rst0");
    step(mk(0,0,0, 0,0,0,0,0), "rst1");
    reset = 1'b0;

    for (int i = 0; i < 13; i++) step(tab_a[i], $sformatf("A%0d", i));

    // Lockout with iniciar and res_valid held: 15 more blocked cycles, then IDLE.
    for (int i = 0; i < 15; i++) step(mk(1,1,0, 0,0,1,3,3), $sformatf("L%0d", i));
    step(mk(1,0,0, 0,0,0,0,0), "lock_exit");

    for (int i = 0; i < 13; i++) step(tab_b[i], $sformatf("B%0d", i));

    // Reset in the middle of a lockout clears everything in one cycle.
    for (int i = 0; i < 3; i++) step(mk(0,0,0, 0,0,1,3,3), $sformatf("M%0d", i));
    reset = 1'b1;
    step(mk(1,0,0, 0,0,0,0,0), "rst_locked");
    reset = 1'b0;
    step(mk(0,0,0, 0,0,0,0,0), "post_rst");

`ifdef LOCK_ATTEMPT_TIMEOUT_EN
    // No verdict: forced failure on the 8th CHECK cycle.
    step(mk(1,0,0, 1,0,0,0,1), "T_start");
    for (int i = 0; i < 7; i++) step(mk(0,0,0, 0,0,0,0,1), $sformatf("T_wait%0d", i));
    step(mk(0,0,0, 0,0,0,1,0), "T_expire");
    // Verdict in the expiry cycle wins.
    step(mk(1,0,0, 1,0,0,1,1), "T2_start");
    for (int i = 0; i < 7; i++) step(mk(0,0,0, 0,0,0,1,1), $sformatf("T2_wait%0d", i));
    step(mk(0,1,1, 0,1,0,0,2), "T2_verdict");
`else
    // Without the timeout CHECK waits indefinitely.
    step(mk(1,0,0, 1,0,0,0,1), "W_start");
    for (int i = 0; i < 20; i++) step(mk(0,0,0, 0,0,0,0,1), $sformatf("W_wait%0d", i));
    step(mk(0,1,0, 0,0,0,1,0), "W_fail");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
